gamepad_pmod_rx: RTL

Parametrised receiver for the Gamepad Pmod serial stream, supporting 1..4 chained controllers. It synchronises pmod_data, pmod_clk and pmod_latch, shifts data in, and validates each frame's bit count. It decodes per-pad button and presence state and emits per-button press/release event pulses. It sits between the ui_in pins and game/VGA logic, and adds a link watchdog that forces "not present" when the Pmod goes silent.

---
 rtl/gamepad_pmod_rx.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/gamepad_pmod_rx.sv
// Gamepad Pmod serial receiver for 1..4 chained pads with frame-length check,
// event pulses and link watchdog. Optional auto-repeat: GAMEPAD_AUTOREPEAT_EN.
module gamepad_pmod_rx #(
  parameter int unsigned N_PADS         = 2,
  parameter int unsigned TIMEOUT_CYCLES = 2500000,
  parameter int unsigned REPEAT_DELAY   = 16,
  parameter int unsigned REPEAT_PERIOD  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pmod_data,
  input  logic                  pmod_clk,
  input  logic                  pmod_latch,
  output logic [12*N_PADS-1:0]  buttons,
  output logic [N_PADS-1:0]     present,
  output logic [12*N_PADS-1:0]  press_evt,
  output logic [12*N_PADS-1:0]  release_evt,
  output logic                  frame_valid,
  output logic                  frame_err,
  output logic                  link_timeout
);
  localparam int unsigned W   = 12 * N_PADS;
  localparam int unsigned WDW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  if (N_PADS < 1 || N_PADS > 4 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 ||
      REPEAT_DELAY + REPEAT_PERIOD > 31) begin : g_cfg_check
    $error("gamepad_pmod_rx: unsupported parameter set");
  end

  logic [1:0]     data_s_q, clk_s_q, latch_s_q;
  logic           clk_prev_q, latch_prev_q;
  logic [W-1:0]   shift_q, data_q;
  logic [5:0]     cnt_q;
  logic [WDW-1:0] wd_q;
  logic           wd_fired_q;
  logic           acc_q, err_q, to_q;
  logic [W-1:0]   buttons_q, press_q, release_q;
  logic [N_PADS-1:0] present_q;
  logic           fv_q, fe_q, lto_q;

  logic           clk_edge, latch_edge, len_ok, accept, reject, timeout;
  logic [W-1:0]   shift_sh, dec_btn, rpt;
  logic [5:0]     cnt_sh;
  logic [N_PADS-1:0] dec_pres;

  assign clk_edge   = clk_s_q[1] & ~clk_prev_q;
  assign latch_edge = latch_s_q[1] & ~latch_prev_q;

  // A clock edge coinciding with the latch is shifted and counted before the frame is judged.
  always_comb begin
    shift_sh = clk_edge ? {shift_q[W-2:0], data_s_q[1]} : shift_q;
    cnt_sh   = (clk_edge && cnt_q != 6'd63) ? cnt_q + 6'd1 : cnt_q;
    len_ok   = 1'b0;
    for (int unsigned k = 1; k <= N_PADS; k++) begin
      if (cnt_sh == 6'(12 * k)) len_ok = 1'b1;
    end
    accept  = latch_edge & len_ok;
    reject  = latch_edge & ~len_ok;
    timeout = (TIMEOUT_CYCLES != 0) && !accept && !wd_fired_q && (wd_q == WD_LAST);
  end

  always_comb begin
    dec_btn  = '0;
    dec_pres = '0;
    for (int unsigned k = 0; k < N_PADS; k++) begin
      if (data_q[12*k +: 12] != 12'hFFF) begin
        dec_pres[k]        = 1'b1;
        dec_btn[12*k +: 12] = data_q[12*k +: 12];
      end
    end
  end

`ifdef GAMEPAD_AUTOREPEAT_EN
  localparam logic [4:0] RPT_FIRST = 5'(REPEAT_DELAY);
  localparam logic [4:0] RPT_WRAP  = 5'(REPEAT_DELAY + REPEAT_PERIOD);
  logic [W-1:0][4:0] hold_q, hold_d;
  logic [4:0]        nxt;

  always_comb begin
    hold_d = hold_q;
    rpt    = '0;
    nxt    = '0;
    for (int unsigned i = 0; i < W; i++) begin
      if (!dec_btn[i]) begin
        hold_d[i] = '0;
      end else if (acc_q) begin
        nxt = hold_q[i] + 5'd1;
        // Folding back to the first-repeat count makes later repeats land every period.
        if (nxt == RPT_WRAP) nxt = RPT_FIRST;
        hold_d[i] = nxt;
        rpt[i]    = (nxt == RPT_FIRST) && buttons_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) hold_q <= '0;
    else        hold_q <= hold_d;
  end
`else
  assign rpt = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_s_q     <= '0;
      clk_s_q      <= '0;
      latch_s_q    <= '0;
      clk_prev_q   <= 1'b0;
      latch_prev_q <= 1'b0;
      shift_q      <= '1;
      data_q       <= '1;
      cnt_q        <= '0;
      wd_q         <= '0;
      wd_fired_q   <= 1'b0;
      acc_q        <= 1'b0;
      err_q        <= 1'b0;
      to_q         <= 1'b0;
      buttons_q    <= '0;
      present_q    <= '0;
      press_q      <= '0;
      release_q    <= '0;
      fv_q         <= 1'b0;
      fe_q         <= 1'b0;
      lto_q        <= 1'b0;
    end else begin
      data_s_q     <= {data_s_q[0], pmod_data};
      clk_s_q      <= {clk_s_q[0], pmod_clk};
      latch_s_q    <= {latch_s_q[0], pmod_latch};
      clk_prev_q   <= clk_s_q[1];
      latch_prev_q <= latch_s_q[1];

      if (latch_edge) begin
        shift_q <= '1;
        cnt_q   <= '0;
      end else begin
        shift_q <= shift_sh;
        cnt_q   <= cnt_sh;
      end

      if (accept)       data_q <= shift_sh;
      else if (timeout) data_q <= '1;

      if (accept) begin
        wd_q       <= '0;
        wd_fired_q <= 1'b0;
      end else if (timeout) begin
        wd_fired_q <= 1'b1;
      end else if (TIMEOUT_CYCLES != 0 && wd_q != WD_LAST) begin
        wd_q <= wd_q + 1'b1;
      end

      acc_q <= accept;
      err_q <= reject;
      to_q  <= timeout;

      buttons_q <= dec_btn;
      present_q <= dec_pres;
      press_q   <= (dec_btn & ~buttons_q) | rpt;
      release_q <= ~dec_btn & buttons_q;
      fv_q      <= acc_q;
      fe_q      <= err_q;
      lto_q     <= to_q;
    end
  end

  assign buttons      = buttons_q;
  assign present      = present_q;
  assign press_evt    = press_q;
  assign release_evt  = release_q;
  assign frame_valid  = fv_q;
  assign frame_err    = fe_q;
  assign link_timeout = lto_q;

endmodule
